// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the iteration-counter sizing helper.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring iteration, purely combinational: shift, trial subtract, select.
// The quotient bit is shifted into the LSB of the dividend register as its MSB leaves.
module divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   p_o,
    output logic [WIDTH-1:0] dq_o
);

    logic [WIDTH:0]   p_sh;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic             unused_p_msb;

    // P stays below the divisor, so its top bit is always clear before the shift.
    assign unused_p_msb = p_i[WIDTH];

    always_comb begin
        p_sh  = {p_i[WIDTH-1:0], dq_i[WIDTH-1]};
        diff  = {1'b0, p_sh} - {2'b00, divisor_i};
        q_bit = ~diff[WIDTH+1];
        p_o   = q_bit ? diff[WIDTH:0] : p_sh;
        dq_o  = {dq_i[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, WIDTH+1 cycles per result;
// start is ignored while busy. Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   p_d;
    logic [WIDTH-1:0] dq_d;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg_q;
    logic rneg_q;
`endif

    divider_step #(.WIDTH(WIDTH)) u_step (
        .p_i       (p_q),
        .dq_i      (dq_q),
        .divisor_i (dvs_q),
        .p_o       (p_d),
        .dq_o      (dq_d)
    );

    always_comb begin
        dvd_mag = dividend_i;
        dvs_mag = divisor_i;
        q_fin   = dq_d;
        r_fin   = p_d[WIDTH-1:0];
`ifdef SEQ_DIVIDER_SIGNED_EN
        // Divide magnitudes, then fix signs so the quotient truncates toward zero.
        if (dividend_i[WIDTH-1]) dvd_mag = -dividend_i;
        if (divisor_i[WIDTH-1])  dvs_mag = -divisor_i;
        if (qneg_q)              q_fin   = -dq_d;
        if (rneg_q)              r_fin   = -p_d[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start_i) begin
                        if (divisor_i == '0) begin
                            state_q     <= FIN;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend_i;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(WIDTH);
                            p_q     <= '0;
                            dq_q    <= dvd_mag;
                            dvs_q   <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            qneg_q  <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
                            rneg_q  <= dividend_i[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    dq_q  <= dq_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q     <= FIN;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_fin;
                        remainder_q <= r_fin;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=8); signed vectors run when
// SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dbz;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands, let the next rising edge sample start, sample #1 after it.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after the accept edge until done is seen; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, dbz} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {busy, done, dbz});
        end
        checks++;
        if ({quotient, remainder} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_results got %h want 0000", {quotient, remainder});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
        exp_q = 8'hF8;  // -56 / 7
        exp_r = 8'h00;
`else
        exp_q = 8'd28;
        exp_r = 8'd4;
`endif
        issue(8'd200, 8'd7);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL basic_busy got %b want 10", {busy, done});
        end
        wait_done(lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        checks++;
        if ({quotient, remainder, dbz, busy} !== {exp_q, exp_r, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result got q=%0d r=%0d dbz=%b busy=%b want q=%0d r=%0d dbz=0 busy=0",
                     quotient, remainder, dbz, busy, exp_q, exp_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, quotient, remainder} !== {1'b0, exp_q, exp_r}) begin
            errors++;
            $display("FAIL basic_hold got done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
                     done, quotient, remainder, exp_q, exp_r);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(8'd45, 8'd0);
        wait_done(lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL dbz_latency got %0d want 0", lat);
        end
        checks++;
        if ({quotient, remainder, dbz, busy} !== {8'hFF, 8'd45, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dbz_result got q=%h r=%0d dbz=%b busy=%b want q=ff r=45 dbz=1 busy=0",
                     quotient, remainder, dbz, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL dbz_single_cycle got done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'd255, 8'd1);
        wait_done(lat);
        checks++;
        if ({quotient, remainder} !== {8'd255, 8'd0} || lat !== 8) begin
            errors++;
            $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want q=255 r=0 lat=8",
                     quotient, remainder, lat);
        end
        // Start held high during FIN: accepted at the next edge.
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept got busy/done=%b want 10", {busy, done});
        end
        // Pulse during RUN must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({quotient, remainder} !== {8'd255, 8'd0}) begin
            errors++;
            $display("FAIL b2b_hold got q=%0d r=%0d want q=255 r=0", quotient, remainder);
        end
        wait_done(lat);
        checks++;
        if ({quotient, remainder} !== {8'd3, 8'd0} || lat + 1 !== 8) begin
            errors++;
            $display("FAIL b2b_second got q=%0d r=%0d lat=%0d want q=3 r=0 lat=8",
                     quotient, remainder, lat + 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_ignored got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        issue(8'd200, 8'd7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dbz, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
                     busy, done, dbz, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(8'd17, 8'd5);
        wait_done(lat);
        checks++;
        if ({quotient, remainder, dbz} !== {8'd3, 8'd2, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL after_reset got q=%0d r=%0d dbz=%b lat=%0d want q=3 r=2 dbz=0 lat=8",
                     quotient, remainder, dbz, lat);
        end
    endtask

    task automatic test_small_dividend();
        int lat;
        issue(8'd3, 8'd9);
        wait_done(lat);
        checks++;
        if ({quotient, remainder} !== {8'd0, 8'd3} || lat !== 8) begin
            errors++;
            $display("FAIL small got q=%0d r=%0d lat=%0d want q=0 r=3 lat=8",
                     quotient, remainder, lat);
        end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        int lat;
        issue(8'hF9, 8'd2);
        wait_done(lat);
        checks++;
        if ({quotient, remainder} !== {8'hFD, 8'hFF} || lat !== 8) begin
            errors++;
            $display("FAIL signed_m7_2 got q=%h r=%h lat=%0d want q=fd r=ff lat=8",
                     quotient, remainder, lat);
        end
        issue(8'h80, 8'hFF);
        wait_done(lat);
        checks++;
        if ({quotient, remainder} !== {8'h80, 8'h00}) begin
            errors++;
            $display("FAIL signed_wrap got q=%h r=%h want q=80 r=00", quotient, remainder);
        end
        issue(8'h80, 8'h00);
        wait_done(lat);
        checks++;
        if ({quotient, remainder, dbz} !== {8'hFF, 8'h80, 1'b1}) begin
            errors++;
            $display("FAIL signed_dbz got q=%h r=%h dbz=%b want q=ff r=80 dbz=1",
                     quotient, remainder, dbz);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_small_dividend();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Parametrised, multi-cycle restoring divider producing one quotient bit per clock. It is the sequential successor to the team's fixed 4-bit gate-level divider: arbitrary operand width, a start/done handshake, divide-by-zero detection, and an optional signed mode. It sits behind any datapath that issues occasional divides and can tolerate WIDTH-cycle latency in exchange for a single shared subtractor.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2)
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  request; sampled only when accepting (see Operation)
- Dividend  in  WIDTH  captured on accepted Start
- Divisor  in  WIDTH  captured on accepted Start
- Busy  out  1  high while iterating (state RUN)
- Done  out  1  high for exactly one cycle (state FIN); results valid
- Quotient  out  WIDTH  registered result; holds until next FIN
- Remainder  out  WIDTH  registered result; holds until next FIN
- DivByZero  out  1  registered; set with results when Divisor = 0

## Operation
- States: IDLE, RUN, FIN. Busy = (state == RUN); Done = (state == FIN).
- Accepting = state IDLE or FIN. Start while RUN is ignored; operands are not re-sampled.
- Accepted Start, Divisor ≠ 0: load dividend shift register, clear WIDTH+1-bit partial remainder, count = WIDTH, go RUN.
- Accepted Start, Divisor = 0: go straight to FIN; Quotient = all ones, Remainder = Dividend, DivByZero = 1.
- RUN step: P = {P[WIDTH-1:0], dividend MSB}; T = P − {0, Divisor}; if T ≥ 0 then P = T, q-bit = 1, else q-bit = 0; shift q-bit into quotient LSB; count−1. When count reaches 0, write Quotient/Remainder, DivByZero = 0, go FIN.
- FIN: one cycle; then IDLE unless Start is high (back-to-back accept, goes RUN or FIN as above).
- Results are stable outside FIN transitions; a new operation does not disturb Quotient/Remainder until its own FIN.
- Reset (any time, including mid-RUN): state IDLE, Busy 0, Done 0, Quotient 0, Remainder 0, DivByZero 0, internal registers 0; the in-flight operation is discarded.

## Timing
- Start sampled high at edge k (accepting): Busy high from k; WIDTH iterations complete at edges k+1 … k+WIDTH; Done high in the cycle after edge k+WIDTH.
- Divide by zero: Done high in the cycle after edge k.
- Throughput with back-to-back Start: one result every WIDTH+1 cycles.
- Done never asserts on two consecutive cycles except through back-to-back divide-by-zero requests.

## Configuration
- SEQ_DIVIDER_SIGNED_EN defined: operands are two's complement. Magnitudes are divided unsigned; at FIN the quotient is negated if operand signs differ, the remainder takes the dividend's sign (truncation toward zero). Most-negative / −1 wraps: Quotient = most-negative, Remainder = 0. Divide by zero: Quotient = all ones, Remainder = Dividend. Latency unchanged.
- Not defined: unsigned only; no sign logic is synthesised.

## Structure
- Package divider_pkg: state enum typedef (IDLE, RUN, FIN), iteration-counter width constant via $clog2(WIDTH+1).
- One sub-module, divider_step: combinational shift/trial-subtract/select for one restoring iteration, parametrised by WIDTH.

## Test plan
- WIDTH=8 unsigned: Dividend 200, Divisor 7 -> Done 8 cycles after Start edge, Quotient 28, Remainder 4, DivByZero 0.
- Dividend 45, Divisor 0 -> Done the cycle after Start edge, Quotient 0xFF, Remainder 45, DivByZero 1.
- 255/1 then Start held high during FIN with 9/3 -> results 255/0 then, 9 cycles later, 3/0; Start pulse during RUN with 100/10 is ignored.
- Reset asserted mid-RUN at iteration 4 -> all outputs 0 immediately; subsequent 17/5 yields 3/2 with normal latency.
- Dividend 3, Divisor 9 -> Quotient 0, Remainder 3.
- SEQ_DIVIDER_SIGNED_EN: −7/2 -> Quotient 0xFD (−3), Remainder 0xFF (−1); −128/−1 -> Quotient 0x80, Remainder 0.
